// File: rtl/toplayici_hakem.sv
// toplayici_hakem: two-requester arbiter sharing one 4-bit ripple adder.
// A request is granted in IDLE, the captured operands are added in CALC,
// and the result is held in DONE until the consumer acks it.
// Compile-time option: define TOPLAYICI_HAKEM_RR_EN for round-robin tie
// breaking; when left undefined, requester 0 always wins a tie.

// Single-bit full adder cell, one per bit position of the ripple chain.
module tam_toplayici (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

// 4-bit ripple-carry adder with carry-in tied to 0.
module ikili_toplayici (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [3:0] o_sum,
  output logic       o_c4
);
  localparam int W = 4;

  logic [W:0] w_c;

  assign w_c[0] = 1'b0;

  // Carry ripples from bit 0 upward through one cell per bit.
  for (genvar g = 0; g < W; g++) begin : g_bit
    tam_toplayici u_fa (
      .i_a (i_a[g]),
      .i_b (i_b[g]),
      .i_c (w_c[g]),
      .o_s (o_sum[g]),
      .o_c (w_c[g+1])
    );
  end

  assign o_c4 = w_c[W];
endmodule

module toplayici_hakem (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [3:0] a0_in,
  input  logic [3:0] b0_in,
  input  logic       req1,
  input  logic [3:0] a1_in,
  input  logic [3:0] b1_in,
  output logic       gnt0,
  output logic       gnt1,
  output logic [3:0] sum,
  output logic       carry,
  output logic       done,
  output logic       owner,
  input  logic       ack,
  output logic       busy
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] r_state;
  logic       r_gnt0, r_gnt1;
  logic       r_owner;
  logic [3:0] r_a, r_b;
  logic [3:0] r_sum;
  logic       r_carry;
  logic       r_done;

  logic       w_any;
  logic       w_win;
  logic       w_take;
  logic [3:0] w_a, w_b;
  logic [3:0] w_sum;
  logic       w_c4;

  assign w_any  = req0 | req1;
  // A grant happens only on an IDLE edge with at least one request.
  assign w_take = (r_state == S_IDLE) & w_any;

`ifdef TOPLAYICI_HAKEM_RR_EN
  logic r_prio;  // requester that wins the next tie

  // Tie goes to the pointer; a lone request always wins.
  assign w_win = (req0 & req1) ? r_prio : req1;

  // Pointer flips to the requester that was not just served.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)      r_prio <= 1'b0;
    else if (w_take) r_prio <= ~w_win;
`else
  // Fixed priority: requester 1 wins only when requester 0 is idle.
  assign w_win = ~req0;
`endif

  assign w_a = w_win ? a1_in : a0_in;
  assign w_b = w_win ? b1_in : b0_in;

  ikili_toplayici u_add (
    .i_a   (r_a),
    .i_b   (r_b),
    .o_sum (w_sum),
    .o_c4  (w_c4)
  );

  // Control FSM: IDLE -> CALC (always one cycle) -> DONE (until ack).
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else
      case (r_state)
        S_IDLE:  if (w_any) r_state <= S_CALC;
        S_CALC:  r_state <= S_DONE;
        S_DONE:  if (ack) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

  // Grant pulses last exactly the cycle after the arbitration edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
    end else begin
      r_gnt0 <= w_take & ~w_win;
      r_gnt1 <= w_take &  w_win;
    end

  // Winner's operands and index are captured with the grant.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_a     <= 4'd0;
      r_b     <= 4'd0;
      r_owner <= 1'b0;
    end else if (w_take) begin
      r_a     <= w_a;
      r_b     <= w_b;
      r_owner <= w_win;
    end

  // Result registers load only on the CALC edge and otherwise hold.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sum   <= 4'd0;
      r_carry <= 1'b0;
    end else if (r_state == S_CALC) begin
      r_sum   <= w_sum;
      r_carry <= w_c4;
    end

  // done rises entering DONE and falls on the acked edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                         r_done <= 1'b0;
    else if (r_state == S_CALC)         r_done <= 1'b1;
    else if (r_state == S_DONE && ack)  r_done <= 1'b0;
    else if (r_state == S_IDLE)         r_done <= 1'b0;

  assign gnt0  = r_gnt0;
  assign gnt1  = r_gnt1;
  assign sum   = r_sum;
  assign carry = r_carry;
  assign done  = r_done;
  assign owner = r_owner;
  assign busy  = (r_state != S_IDLE);
endmodule

// File: tb/tb_toplayici_hakem.sv
// Bench for toplayici_hakem: directed scenarios with literal expectations,
// then randomized requesters/consumer checked every cycle against a
// transaction-level model of the arbiter.
module tb_toplayici_hakem;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, ack = 1'b0;
  logic [3:0] a0_in = 4'd0, b0_in = 4'd0, a1_in = 4'd0, b1_in = 4'd0;
  logic       gnt0, gnt1, carry, done, owner, busy;
  logic [3:0] sum;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  toplayici_hakem dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0_in(a0_in), .b0_in(b0_in),
    .req1(req1), .a1_in(a1_in), .b1_in(b1_in),
    .gnt0(gnt0), .gnt1(gnt1), .sum(sum), .carry(carry),
    .done(done), .owner(owner), .ack(ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit       m_calc = 0, m_done = 0, m_gnt0 = 0, m_gnt1 = 0, m_owner = 0, m_carry = 0;
  bit [3:0] m_a = 0, m_b = 0, m_sum = 0;
  bit       m_win;
  int       m_tot;
`ifdef TOPLAYICI_HAKEM_RR_EN
  bit       m_prio = 0;
  assign m_win = (req0 && req1) ? m_prio : req1;
`else
  assign m_win = !req0;
`endif
  assign m_tot = int'(m_a) + int'(m_b);

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_calc <= 0; m_done <= 0; m_gnt0 <= 0; m_gnt1 <= 0; m_owner <= 0;
      m_carry <= 0; m_sum <= 0; m_a <= 0; m_b <= 0;
`ifdef TOPLAYICI_HAKEM_RR_EN
      m_prio <= 0;
`endif
    end else begin
      m_gnt0 <= 0;
      m_gnt1 <= 0;
      if (m_calc) begin
        m_sum   <= 4'(m_tot % 16);
        m_carry <= (m_tot >= 16);
        m_done  <= 1;
        m_calc  <= 0;
      end else if (m_done) begin
        if (ack) m_done <= 0;
      end else if (req0 || req1) begin
        m_calc  <= 1;
        m_owner <= m_win;
        m_a     <= m_win ? a1_in : a0_in;
        m_b     <= m_win ? b1_in : b0_in;
        m_gnt0  <= !m_win;
        m_gnt1  <= m_win;
`ifdef TOPLAYICI_HAKEM_RR_EN
        m_prio  <= !m_win;
`endif
      end
    end

  // Every-cycle compare against the model.
  always @(negedge clk)
    if (cmp_en) begin
      chk("gnt0", gnt0, m_gnt0);
      chk("gnt1", gnt1, m_gnt1);
      chk("gnt_excl", gnt0 & gnt1, 0);
      chk("done", done, m_done);
      chk("busy", busy, m_calc | m_done);
      chk("sum", sum, m_sum);
      chk("carry", carry, m_carry);
      if (m_done) chk("owner", owner, m_owner);
    end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit got;
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_done", done, 0);  chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);    chk("rst_carry", carry, 0);
    chk("rst_owner", owner, 0); chk("rst_gnt", {gnt1, gnt0}, 0);
    step(); step();
    rst_n = 1'b1;

    // 3 + 5 from requester 0, acked in first DONE cycle
    a0_in = 4'd3; b0_in = 4'd5; req0 = 1'b1;
    step();
    chk("a_gnt0", gnt0, 1); chk("a_gnt1", gnt1, 0); chk("a_busy", busy, 1);
    req0 = 1'b0;
    step();
    chk("a_done", done, 1); chk("a_sum", sum, 8); chk("a_carry", carry, 0);
    chk("a_owner", owner, 0); chk("a_gnt0_off", gnt0, 0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("a_done_off", done, 0); chk("a_idle", busy, 0); chk("a_sum_hold", sum, 8);

    // 15 + 15 from requester 1, ack withheld 5 cycles
    a1_in = 4'd15; b1_in = 4'd15; req1 = 1'b1;
    step();
    chk("b_gnt1", gnt1, 1);
    req1 = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("b_done", done, 1); chk("b_sum", sum, 14);
      chk("b_carry", carry, 1); chk("b_owner", owner, 1);
      step();
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("b_done_off", done, 0); chk("b_carry_hold", carry, 1);

    // Both requesters held for 4 operations
    rst_n = 1'b0; step(); rst_n = 1'b1;
    a0_in = 4'd1; b0_in = 4'd2; a1_in = 4'd4; b1_in = 4'd8;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      for (int t = 0; t < 10 && !got; t++) begin
        if (done) got = 1; else step();
      end
      if (!got) chk("c_timeout", 0, 1);
`ifdef TOPLAYICI_HAKEM_RR_EN
      chk("c_owner", owner, 8'(k % 2));
`else
      chk("c_owner", owner, 0);
`endif
      ack = 1'b1; step(); ack = 1'b0;
    end
    req0 = 1'b0; req1 = 1'b0;
    step(); step(); step();

    // Reset while in CALC
    a0_in = 4'd7; b0_in = 4'd6; req0 = 1'b1;
    step();
    req0 = 1'b0;
    chk("d_busy_calc", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("d_rst_busy", busy, 0); chk("d_rst_gnt", {gnt1, gnt0}, 0);
    chk("d_rst_done", done, 0); chk("d_rst_sum", sum, 0);
    chk("d_rst_carry", carry, 0); chk("d_rst_owner", owner, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("d_no_done", done, 0);
    end
    a1_in = 4'd9; b1_in = 4'd9; req1 = 1'b1;
    step();
    chk("d_gnt1", gnt1, 1);
    req1 = 1'b0;
    step();
    chk("d_done", done, 1); chk("d_sum", sum, 2);
    chk("d_carry", carry, 1); chk("d_owner", owner, 1);
    ack = 1'b1; step(); ack = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      if (req0) begin
        if (gnt0) begin
          if ($urandom_range(0, 1) == 1) begin
            a0_in = 4'($urandom); b0_in = 4'($urandom);
          end else req0 = 1'b0;
        end else if ($urandom_range(0, 15) == 0) req0 = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        req0 = 1'b1; a0_in = 4'($urandom); b0_in = 4'($urandom);
      end
      if (req1) begin
        if (gnt1) begin
          if ($urandom_range(0, 1) == 1) begin
            a1_in = 4'($urandom); b1_in = 4'($urandom);
          end else req1 = 1'b0;
        end else if ($urandom_range(0, 15) == 0) req1 = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        req1 = 1'b1; a1_in = 4'($urandom); b1_in = 4'($urandom);
      end
      ack = 1'($urandom_range(0, 1));
    end
    req0 = 1'b0; req1 = 1'b0; ack = 1'b0;
    step();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/toplayici_hakem.md
TOPLAYICI_HAKEM -- requirements
Module: toplayici_hakem

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 4 bits.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0  input  1  requester 0 wants an addition; held until gnt0.
REQ-005 a0_in, b0_in  input  4  requester 0 operands, bit 0 = LSB.
REQ-006 req1  input  1  requester 1 wants an addition; held until gnt1.
REQ-007 a1_in, b1_in  input  4  requester 1 operands, bit 0 = LSB.
REQ-008 gnt0, gnt1  output  1  one-cycle grant pulse; operands captured that cycle.
REQ-009 sum  output  4  registered result of the granted addition.
REQ-010 carry  output  1  registered carry-out (c4) of the granted addition.
REQ-011 done  output  1  result valid; held until ack.
REQ-012 owner  output  1  index of the requester the result belongs to; valid while done=1.
REQ-013 ack  input  1  result consumer accepts result; ignored unless done=1.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The block SHALL instantiate ikili_toplayici (4-bit ripple adder, carry-in 0) as its only adder, shared by both requesters.
REQ-016 FSM states SHALL be IDLE, CALC, DONE; no other reachable state.
REQ-017 IDLE: on an edge with req0|req1, SHALL latch winner's operands and owner, pulse the winner's gnt for exactly the following cycle, move to CALC.
REQ-018 IDLE with no request SHALL stay in IDLE with gnt0=gnt1=0.
REQ-019 CALC: on the next edge, SHALL register adder sum and c4 into sum/carry, assert done, move to DONE (one cycle in CALC, always).
REQ-020 DONE: SHALL hold done, sum, carry, owner stable until an edge with ack=1, then clear done and return to IDLE.
REQ-021 Latency: request sampled at edge N -> gnt high after N -> done high after N+1; minimum issue interval 3 cycles (ack in first DONE cycle).
REQ-022 Requests SHALL NOT be sampled in CALC or DONE; a request arriving then waits; one deasserted before its gnt is dropped without effect.
REQ-023 Simultaneous req0 and req1 SHALL be resolved per REQ-031; the loser keeps waiting and is served on the next IDLE arbitration.
REQ-024 Sum/carry SHALL keep the last result after done falls; only a new CALC or reset changes them.
REQ-025 Overflow SHALL appear only on carry; sum wraps modulo 16 (e.g. 15+15 -> sum=14, carry=1).
REQ-026 gnt0 and gnt1 SHALL never be high in the same cycle.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, gnt0=gnt1=0, done=0, busy=0, sum=0, carry=0, owner=0, priority pointer to requester 0.
REQ-028 Reset in CALC or DONE SHALL discard the operation; no done pulse follows deassertion.
REQ-029 After rst_n rises, the first arbitration SHALL occur on the first clk edge with a request.

Configuration
REQ-030 Macro TOPLAYICI_HAKEM_RR_EN SHALL select the arbitration policy at compile time.
REQ-031 Defined: round-robin; a one-bit last-served pointer updates on each grant and the other requester wins a tie. Undefined: fixed priority, requester 0 always wins a tie, no pointer register.

Verification
REQ-032 req0, a0_in=3, b0_in=5, ack on first done cycle -> gnt0 one cycle, done one edge later, sum=8, carry=0, owner=0.
REQ-033 req1, a1_in=15, b1_in=15 -> sum=14, carry=1, owner=1; ack held low 5 cycles -> done/sum/carry stable all 5 cycles.
REQ-034 req0 and req1 held together for 4 ops -> RR_EN: owners 0,1,0,1; without RR_EN: owners 0,0,0,0 while req0 held.
REQ-035 rst_n pulsed low while in CALC -> all outputs 0 immediately, no done after release, next request served normally.
REQ-036 ack=1 while IDLE and CALC, new req during DONE -> no state change from ack; new req granted only after return to IDLE; gnt0&gnt1 never both 1.
